pulse_sequencer: RTL and testbench

Multi-channel timing controller that drives the optical sync-pulse channels from one trigger. Holds per-channel delay/duration configuration, runs one frame per trigger (external sync input or internal period timer), and generates each channel's gated pulse plus a completion strobe. Sits between the host configuration interface and the channel output drivers; it replaces per-channel free-running pulse logic with a single frame counter.

---
 rtl/pulse_seq_pkg.sv | 22 ++
 rtl/trig_sync_edge.sv | 28 ++
 rtl/pulse_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pulse_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared types and address map for the pulse sequencer
package pulse_seq_pkg;

    localparam int CW_DEFAULT = 36;
    localparam int NCH_MAX    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_HOLDOFF
    } seq_state_t;

    function automatic logic [3:0] ADDR_DELAY(input int ch);
        return 4'(2 * ch);
    endfunction

    function automatic logic [3:0] ADDR_DUR(input int ch);
        return 4'(2 * ch + 1);
    endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// rtl/trig_sync_edge.sv - two-flop synchronizer and rising-edge detect for the external trigger
module trig_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Combinational so the FSM consumes the edge one cycle after r_sync rises.
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - frame-based multi-channel delay/duration pulse generator
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CW      = CW_DEFAULT,
    parameter int HOLDOFF = 16
) (
    input  logic           clk_Pulse,
    input  logic           rst,
    input  logic           arm,
    input  logic           mode_ext,
    input  logic           ext_trig,
    input  logic [CW-1:0]  period,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_addr,
    input  logic [CW-1:0]  cfg_data,
    output logic [NCH-1:0] ch_out,
    output logic [NCH-1:0] ch_launch,
    output logic           busy,
    output logic           frame_done,
    output logic           trig_miss,
    output logic           cfg_err
);

    localparam int HW = $clog2(HOLDOFF + 1);

    seq_state_t    r_state;
    logic [CW-1:0] r_delay [NCH];
    logic [CW-1:0] r_dur   [NCH];
    logic [CW-1:0] r_per_cnt;
    logic [CW:0]   r_cnt;
    logic [HW-1:0] r_hold;
    logic          r_frame_done;
    logic          r_trig_miss;
    logic          r_cfg_err;

    logic           w_ext_rise;
    logic           w_per_en;
    logic           w_int_trig;
    logic           w_trig;
    logic           w_cfg_open;
    logic           w_addr_ok;
    logic           w_run;
    logic           w_frame_end;
    logic [CW:0]    w_end [NCH];
    logic [CW:0]    w_max_end;
    logic [NCH-1:0] w_on;
    logic [NCH-1:0] w_out;
    logic [NCH-1:0] w_launch;

    trig_sync_edge u_sync (
        .i_clk   (clk_Pulse),
        .i_rst   (rst),
        .i_async (ext_trig),
        .o_rise  (w_ext_rise)
    );

    assign w_cfg_open = (r_state == ST_IDLE) || (r_state == ST_ARMED);
    assign w_addr_ok  = ({1'b0, cfg_addr} < 5'(2 * NCH));

    always_ff @(posedge clk_Pulse) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_delay[i] <= '0;
                r_dur[i]   <= '0;
            end
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !(w_cfg_open && w_addr_ok);
            if (cfg_we && w_cfg_open && w_addr_ok) begin
                for (int i = 0; i < NCH; i++) begin
                    if (cfg_addr == ADDR_DELAY(i)) r_delay[i] <= cfg_data;
                    if (cfg_addr == ADDR_DUR(i))   r_dur[i]   <= cfg_data;
                end
            end
        end
    end

    // The period timer free-runs across frames so a short period never slips phase.
    assign w_per_en   = (r_state != ST_IDLE) && !mode_ext && (period != '0);
    assign w_int_trig = w_per_en && (r_per_cnt == period - CW'(1));
    assign w_trig     = mode_ext ? w_ext_rise : w_int_trig;

    always_ff @(posedge clk_Pulse) begin
        if (rst || !w_per_en) begin
            r_per_cnt <= '0;
        end else if (w_int_trig) begin
            r_per_cnt <= '0;
        end else begin
            r_per_cnt <= r_per_cnt + 1'b1;
        end
    end

    always_comb begin
        w_max_end = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_dur[i] != '0 && w_end[i] > w_max_end) w_max_end = w_end[i];
        end
    end

    assign w_frame_end = (r_cnt >= w_max_end);

    always_ff @(posedge clk_Pulse) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_frame_done <= 1'b0;
            r_trig_miss  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_trig_miss  <= 1'b0;
            if (!arm) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_hold  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_ARMED;
                    ST_ARMED: begin
                        if (w_trig) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                        end
                    end
                    ST_RUN: begin
                        r_trig_miss <= w_trig;
                        if (w_frame_end) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_HOLDOFF;
                            r_hold       <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_HOLDOFF: begin
                        r_trig_miss <= w_trig;
                        if (r_hold == HW'(HOLDOFF - 1)) r_state <= ST_ARMED;
                        else                            r_hold  <= r_hold + 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_run = (r_state == ST_RUN) && arm;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic r_out;
        logic r_launch;

        assign w_end[g] = {1'b0, r_delay[g]} + {1'b0, r_dur[g]};
        assign w_on[g]  = (r_dur[g] != '0) && (r_cnt >= {1'b0, r_delay[g]}) && (r_cnt < w_end[g]);

        // Launch is registered alongside the falling output so the last one lines up with frame_done.
        always_ff @(posedge clk_Pulse) begin
            if (rst || !w_run) begin
                r_out    <= 1'b0;
                r_launch <= 1'b0;
            end else begin
                r_out    <= w_on[g];
                r_launch <= r_out & ~w_on[g];
            end
        end

        assign w_out[g]    = r_out;
        assign w_launch[g] = r_launch;
    end

    assign ch_out     = w_out;
    assign ch_launch  = w_launch;
    assign busy       = (r_state == ST_RUN) || (r_state == ST_HOLDOFF);
    assign frame_done = r_frame_done;
    assign trig_miss  = r_trig_miss;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - self-checking bench for pulse_sequencer
module tb_pulse_sequencer;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int HO  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           arm;
    logic           mode_ext;
    logic           ext_trig;
    logic [CW-1:0]  period;
    logic           cfg_we;
    logic [3:0]     cfg_addr;
    logic [CW-1:0]  cfg_data;
    logic [NCH-1:0] ch_out;
    logic [NCH-1:0] ch_launch;
    logic           busy;
    logic           frame_done;
    logic           trig_miss;
    logic           cfg_err;

    always #5 clk = ~clk;

    pulse_sequencer #(.NCH(NCH), .CW(CW), .HOLDOFF(HO)) dut (
        .clk_Pulse  (clk),
        .rst        (rst),
        .arm        (arm),
        .mode_ext   (mode_ext),
        .ext_trig   (ext_trig),
        .period     (period),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .ch_out     (ch_out),
        .ch_launch  (ch_launch),
        .busy       (busy),
        .frame_done (frame_done),
        .trig_miss  (trig_miss),
        .cfg_err    (cfg_err)
    );

    typedef struct packed {
        logic [3:0][7:0] dly;
        logic [3:0][7:0] dur;
        logic [7:0]      trig2;
        logic [9:0]      exp_fd_m;
    } frame_vec_t;

    int          checks = 0;
    int          errors = 0;
    int          m_dly [4];
    int          m_dur [4];
    logic [10:0] exp_q [$];
    logic [1:0]  p5_q [$];
    int          rise_q [$];
    frame_vec_t  vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_vec_t mk(input int d0, u0, d1, u1, d2, u2, d3, u3, t2, fd);
        frame_vec_t v;
        v.dly      = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        v.dur      = {8'(u3), 8'(u2), 8'(u1), 8'(u0)};
        v.trig2    = 8'(t2);
        v.exp_fd_m = 10'(fd);
        return v;
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d, input logic exp_err, input string name);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        check(name, cfg_err, exp_err);
    endtask

    task automatic write_all();
        for (int i = 0; i < NCH; i++) begin
            cfg_write(4'(2 * i), 8'(m_dly[i]), 1'b0, "cfg_dly_ok");
            cfg_write(4'(2 * i + 1), 8'(m_dur[i]), 1'b0, "cfg_dur_ok");
        end
    endtask

    // Trigger at m=0, optional second trigger at m=trig2; each expected trace word is queued before driving.
    task automatic run_frame(input int trig2, input string tag, output int fd_m);
        int          fend;
        int          last;
        logic [3:0]  e_out;
        logic [3:0]  e_l;
        logic [10:0] got;
        fend = 0;
        for (int i = 0; i < NCH; i++)
            if (m_dur[i] != 0 && m_dly[i] + m_dur[i] > fend) fend = m_dly[i] + m_dur[i];
        last = 3 + fend + HO;
        for (int m = 0; m <= last; m++) begin
            for (int i = 0; i < NCH; i++) begin
                e_out[i] = (m_dur[i] != 0) && (m >= 3 + m_dly[i]) && (m < 3 + m_dly[i] + m_dur[i]);
                e_l[i]   = (m_dur[i] != 0) && (m == 3 + m_dly[i] + m_dur[i]);
            end
            exp_q.push_back({e_out, e_l, 1'(m == 3 + fend), 1'(m >= 2 && m < 3 + fend + HO),
                             1'(trig2 != 0 && m == trig2 + 2)});
        end
        fd_m = -1;
        for (int m = 0; m <= last; m++) begin
            @(negedge clk);
            ext_trig = (m == 0) || (trig2 != 0 && m == trig2);
            @(posedge clk);
            #1;
            got = {ch_out, ch_launch, frame_done, busy, trig_miss};
            if (frame_done && fd_m < 0) fd_m = m;
            check($sformatf("%s m=%0d", tag, m), got, exp_q.pop_front());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd;
        int prev;
        int rises;
        int falls;
        int misses;
        int rise_t;
        int seen;
        int tt;
        int nfree;
        logic trig;
        logic start;

        vecs[0] = mk(0, 5, 3, 2, 0, 0, 0, 0, 4, 8);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[2] = mk(2, 3, 0, 1, 7, 4, 1, 0, 0, 14);
        vecs[3] = mk(9, 0, 0, 0, 0, 0, 6, 1, 0, 10);
        vecs[4] = mk(255, 255, 0, 0, 0, 0, 0, 0, 0, 513);

        rst = 1'b1; arm = 1'b0; mode_ext = 1'b1; ext_trig = 1'b0; period = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ch_out", ch_out, 0);
        check("rst_flags", {ch_launch, busy, frame_done, trig_miss, cfg_err}, 0);
        rst = 1'b0;
        arm = 1'b1;
        @(negedge clk);
        check("armed_not_busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NCH; i++) begin
                m_dly[i] = int'(vecs[v].dly[i]);
                m_dur[i] = int'(vecs[v].dur[i]);
            end
            write_all();
            run_frame(int'(vecs[v].trig2), $sformatf("vec%0d", v), fd);
            check($sformatf("vec%0d_fd_m", v), fd, vecs[v].exp_fd_m);
        end

        // Rejected writes: during RUN and out-of-range address; frame keeps the old delay2.
        m_dly = '{0, 0, 5, 0};
        m_dur = '{0, 0, 20, 0};
        write_all();
        @(negedge clk); ext_trig = 1'b1;
        @(negedge clk); ext_trig = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_in_run", busy, 1);
        cfg_write(4'd4, 8'd0, 1'b1, "cfg_err_run");
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        check("run_drains", busy, 0);
        cfg_write(4'd12, 8'h33, 1'b1, "cfg_err_addr");
        run_frame(0, "old_delay2", fd);
        check("old_delay2_fd", fd, 28);

        // Internal period 100: rises on a fixed 100-cycle grid, width 10.
        m_dly = '{0, 0, 0, 0};
        m_dur = '{10, 0, 0, 0};
        write_all();
        @(negedge clk);
        mode_ext = 1'b0;
        period   = 8'd100;
        for (int k = 0; k < 20; k++) rise_q.push_back(101 + 100 * k);
        prev = 0; rises = 0; falls = 0; misses = 0; rise_t = 0;
        for (int t = 1; t <= 2200 && falls < 20; t++) begin
            @(posedge clk);
            #1;
            if (trig_miss) misses++;
            if (ch_out[0] && prev == 0) begin
                rises++;
                check("int_rise_t", t, (rise_q.size() > 0) ? rise_q.pop_front() : -1);
                rise_t = t;
            end
            if (!ch_out[0] && prev == 1) begin
                falls++;
                check("int_width", t - rise_t, 10);
            end
            prev = int'(ch_out[0]);
        end
        check("int_rises", rises, 20);
        check("int_no_miss", misses, 0);

        // Period 5 with 27-cycle busy window: misses, and a frame on every 6th period.
        @(negedge clk); arm = 1'b0; period = 8'd5;
        @(negedge clk); arm = 1'b1;
        tt = -100; nfree = 0;
        for (int t = 1; t <= 100; t++) begin
            trig  = (t >= 2) && ((t - 2) % 5 == 4);
            start = 1'b0;
            if (trig && t >= nfree) begin
                tt    = t;
                nfree = t + 28;
                start = 1'b1;
            end
            p5_q.push_back({trig && !start, 1'(t >= tt + 1 && t <= tt + 10)});
        end
        for (int t = 1; t <= 100; t++) begin
            @(posedge clk);
            #1;
            check($sformatf("p5 t=%0d", t), {trig_miss, ch_out[0]}, p5_q.pop_front());
        end

        // Abort by arm mid-pulse.
        @(negedge clk); arm = 1'b0; mode_ext = 1'b1; period = '0;
        @(negedge clk); arm = 1'b1;
        write_all();
        @(negedge clk); ext_trig = 1'b1;
        @(negedge clk); ext_trig = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_pre", ch_out[0], 1);
        arm = 1'b0;
        @(negedge clk);
        check("abort_out", ch_out, 0);
        check("abort_busy", busy, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (ch_launch != 0 || frame_done) seen = 1;
            @(negedge clk);
        end
        check("abort_quiet", seen, 0);

        // Abort by reset mid-pulse; configuration returns to zero.
        arm = 1'b1;
        @(negedge clk); ext_trig = 1'b1;
        @(negedge clk); ext_trig = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pre", ch_out[0], 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out", {ch_out, ch_launch, busy, frame_done}, 0);
        rst = 1'b0;
        m_dly = '{0, 0, 0, 0};
        m_dur = '{0, 0, 0, 0};
        run_frame(0, "post_rst", fd);
        check("post_rst_fd", fd, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
